// File: rtl/dsp_adder48.sv
// Pipelined 48-bit two's-complement adder (A + B -> OUT1), latency 2 (INREG=1) or 1 (INREG=0).
// Accepts a pair every clock and never stalls; `DSP_ADDER48_SAT_EN selects a saturating add instead of wrap.
module dsp_adder48 #(
  parameter int INREG = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [47:0] AIN1,
  input  logic [47:0] BIN1,
  output logic [47:0] OUT1
);

  logic [47:0] w_a;
  logic [47:0] w_b;
  logic [47:0] w_res;
  logic [47:0] r_out;

  if (INREG != 0) begin : g_inreg
    logic [47:0] r_a_q;
    logic [47:0] r_b_q;

    always_ff @(posedge CLK) begin
      if (!RST) begin
        r_a_q <= '0;
        r_b_q <= '0;
      end else begin
        r_a_q <= AIN1;
        r_b_q <= BIN1;
      end
    end

    assign w_a = r_a_q;
    assign w_b = r_b_q;
  end else begin : g_noinreg
    assign w_a = AIN1;
    assign w_b = BIN1;
  end

`ifdef DSP_ADDER48_SAT_EN
  // Sign-extended 49-bit sum: bits 48 and 47 disagree exactly when the 48-bit result overflowed,
  // and bit 48 is the true sign, which picks the clamp direction.
  logic [48:0] w_sum49;
  logic        w_ovf;

  assign w_sum49 = {w_a[47], w_a} + {w_b[47], w_b};
  assign w_ovf   = w_sum49[48] ^ w_sum49[47];

  always_comb begin
    w_res = w_sum49[47:0];
    if (w_ovf) begin
      w_res = w_sum49[48] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
    end
  end
`else
  assign w_res = w_a + w_b;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_out <= '0;
    end else begin
      r_out <= w_res;
    end
  end

  assign OUT1 = r_out;

endmodule

// File: tb/tb_dsp_adder48.sv
// Directed bench for dsp_adder48 (INREG=1): arithmetic model compared every cycle plus literal checks.
module tb_dsp_adder48;

  logic        CLK;
  logic        RST;
  logic [47:0] AIN1;
  logic [47:0] BIN1;
  logic [47:0] OUT1;

  int n_pass  = 0;
  int n_total = 0;

  logic        hist_rst[$];
  logic [47:0] hist_a[$];
  logic [47:0] hist_b[$];

  localparam logic [47:0] MAXP = 48'h7FFF_FFFF_FFFF;
  localparam logic [47:0] MINN = 48'h8000_0000_0000;
  localparam logic [47:0] ALL1 = 48'hFFFF_FFFF_FFFF;

  dsp_adder48 #(.INREG(1)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .AIN1 (AIN1),
    .BIN1 (BIN1),
    .OUT1 (OUT1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: true signed sum in 64-bit arithmetic, then wrap or clamp to 48 bits.
  function automatic logic [47:0] model_sum(input logic [47:0] a, input logic [47:0] b);
    longint sa, sb, s, lim_hi, lim_lo;
    logic [63:0] u;
    sa = $signed(a);
    sb = $signed(b);
    s  = sa + sb;
    lim_hi = (longint'(1) <<< 47) - 1;
    lim_lo = -(longint'(1) <<< 47);
`ifdef DSP_ADDER48_SAT_EN
    if (s > lim_hi) s = lim_hi;
    if (s < lim_lo) s = lim_lo;
`else
    if (s > lim_hi || s < lim_lo) s = s;
`endif
    u = s;
    return u[47:0];
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: OUT1=%h expected %h at %0t", name, act, exp, $time);
  endtask

  always @(posedge CLK) begin
    hist_rst.push_back(RST);
    hist_a.push_back(AIN1);
    hist_b.push_back(BIN1);
  end

  // After edge k the output holds reset (0) if either of the last two edges was in reset,
  // otherwise the sum of the operands sampled one edge earlier.
  always @(negedge CLK) begin
    int k;
    logic [47:0] exp;
    k = hist_rst.size() - 1;
    if (k >= 1) begin
      if (!hist_rst[k] || !hist_rst[k-1]) exp = '0;
      else exp = model_sum(hist_a[k-1], hist_b[k-1]);
      check("model", OUT1, exp);
    end
  end

  task automatic drive(input logic r, input logic [47:0] a, input logic [47:0] b);
    RST  = r;
    AIN1 = a;
    BIN1 = b;
    @(negedge CLK);
  endtask

  initial begin
    logic [47:0] exp_posovf, exp_negovf;
`ifdef DSP_ADDER48_SAT_EN
    exp_posovf = MAXP;
    exp_negovf = MINN;
`else
    exp_posovf = 48'hFFFF_FFFF_FFFD;
    exp_negovf = MAXP;
`endif

    // Model self-pins with literal operands.
    check("model_small", model_sum(48'd2020, 48'd2020), 48'h000000000FC8);
    check("model_wrap0", model_sum(ALL1, 48'd1), 48'h0);
    check("model_posovf", model_sum(MAXP, 48'h7FFF_FFFF_FFFE), exp_posovf);

    drive(1'b0, 48'd123, 48'd456);
    drive(1'b0, 48'd789, 48'd321);
    check("reset_out", OUT1, 48'h0);

    drive(1'b1, 48'd5, 48'd7);
    check("pre_latency", OUT1, 48'h0);
    drive(1'b1, MAXP, 48'h7FFF_FFFF_FFFE);
    check("five_plus_seven", OUT1, 48'h00C);
    drive(1'b1, 48'd2020, 48'd2020);
    check("pos_overflow", OUT1, exp_posovf);
    drive(1'b1, 48'd1115, 48'd1115);
    check("a_b_2020", OUT1, 48'h000000000FC8);
    drive(1'b1, 48'd1234, 48'd1234);
    check("a_b_1115", OUT1, 48'h0000000008B6);
    drive(1'b1, ALL1, 48'd1);
    check("a_b_1234", OUT1, 48'h0000000009A4);
    drive(1'b1, MINN, ALL1);
    check("minus1_plus1", OUT1, 48'h0);
    drive(1'b1, 48'd1, 48'd1);
    check("neg_overflow", OUT1, exp_negovf);

    drive(1'b1, 48'd2, 48'd2);
    check("stream_2", OUT1, 48'd2);
    drive(1'b1, 48'd3, 48'd3);
    check("stream_4", OUT1, 48'd4);
    drive(1'b1, 48'd4, 48'd4);
    check("stream_6", OUT1, 48'd6);
    drive(1'b1, 48'd10, 48'd20);
    check("stream_8", OUT1, 48'd8);

    // One-edge reset mid-stream: 10+20 and 100+200 are both lost.
    drive(1'b0, 48'd100, 48'd200);
    check("midrst_out", OUT1, 48'h0);
    drive(1'b1, 48'd5, 48'd6);
    check("midrst_drop", OUT1, 48'h0);
    drive(1'b1, 48'd7, 48'd8);
    check("resume_1", OUT1, 48'hB);
    drive(1'b1, 48'h0000_1234_5678, 48'hFFFF_FFFF_FFF0);
    check("resume_2", OUT1, 48'hF);

    // Held operands give a constant output.
    for (int i = 0; i < 3; i++) drive(1'b1, 48'h0000_1234_5678, 48'hFFFF_FFFF_FFF0);
    check("hold_const", OUT1, 48'h0000_1234_5668);

    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
